// File: rtl/uart_bus_sched.sv
// Bus master for the simple_uart register port: round-robin TX sharing between two requesters,
// RX drain into a one-cycle strobe, and baud-divider updates deferred until the transmitter idles.
module uart_bus_sched #(
    parameter logic [15:0] BAUD_DIV = 16'd2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [7:0]  req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [7:0]  req1_data_i,
    output logic        req1_ready_o,
    input  logic        cfg_we_i,
    input  logic [15:0] cfg_div_i,
    output logic        cfg_busy_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_fe_o,
    output logic        uart_sel_o,
    output logic        uart_we_o,
    output logic [1:0]  uart_addr_o,
    output logic [31:0] uart_wdata_o,
    input  logic [31:0] uart_rdata_i
);

    localparam logic [1:0] AddrOdr = 2'd0;
    localparam logic [1:0] AddrIdr = 2'd1;
    localparam logic [1:0] AddrBsr = 2'd2;
    localparam logic [1:0] AddrSr  = 2'd3;

    typedef enum logic [2:0] {
        StInit, StIdle, StSrWait, StDecide, StIdWait, StClr, StGuard
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [2:0]  r_sr;
    logic        r_pending;
    logic [15:0] r_div;
    logic        r_last_gnt;  // 1: requester 1 was granted last
    logic        w_rx_sel;
    logic        w_cfg_sel;
    logic        w_tx_sel;
    logic        w_grant1;
    logic        w_unused;

    assign w_rx_sel  = r_sr[1];
    assign w_cfg_sel = !r_sr[1] && r_pending && !r_sr[0];
    assign w_tx_sel  = !r_sr[1] && !r_pending && !r_sr[0] && (req0_valid_i || req1_valid_i);
    assign w_grant1  = req1_valid_i && (!req0_valid_i || !r_last_gnt);
    assign cfg_busy_o = r_pending;
    assign w_unused   = ^uart_rdata_i[31:8];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sr       <= 3'd0;
            r_pending  <= 1'b0;
            r_div      <= 16'd0;
            r_last_gnt <= 1'b1;
        end else begin
            if (r_state == StSrWait) begin
                r_sr <= uart_rdata_i[2:0];
            end
            // A fresh request wins over the clear so a late update is never lost.
            if (cfg_we_i) begin
                r_pending <= 1'b1;
                r_div     <= cfg_div_i;
            end else if (r_state == StDecide && w_cfg_sel) begin
                r_pending <= 1'b0;
            end
            if (r_state == StDecide && w_tx_sel) begin
                r_last_gnt <= w_grant1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StInit:   w_state_next = StIdle;
            StIdle:   w_state_next = StSrWait;
            StSrWait: w_state_next = StDecide;
            StDecide: begin
                if (w_rx_sel) begin
                    w_state_next = StIdWait;
                end else if (w_cfg_sel || w_tx_sel) begin
                    w_state_next = StGuard;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StIdWait: w_state_next = StClr;
            StClr:    w_state_next = StIdle;
            StGuard:  w_state_next = StIdle;
            default:  w_state_next = StInit;
        endcase
    end

    // Outputs are forced low while reset is held so an aborted access never reaches the UART.
    always_comb begin
        uart_sel_o   = 1'b0;
        uart_we_o    = 1'b0;
        uart_addr_o  = 2'd0;
        uart_wdata_o = 32'd0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rx_valid_o   = 1'b0;
        rx_data_o    = 8'd0;
        rx_fe_o      = 1'b0;
        if (rst_i) begin
            unique case (r_state)
                StInit: begin
                    uart_sel_o   = 1'b1;
                    uart_we_o    = 1'b1;
                    uart_addr_o  = AddrBsr;
                    uart_wdata_o = {16'd0, BAUD_DIV};
                end
                StIdle: begin
                    uart_sel_o  = 1'b1;
                    uart_addr_o = AddrSr;
                end
                StDecide: begin
                    if (w_rx_sel) begin
                        uart_sel_o  = 1'b1;
                        uart_addr_o = AddrIdr;
                    end else if (w_cfg_sel) begin
                        uart_sel_o   = 1'b1;
                        uart_we_o    = 1'b1;
                        uart_addr_o  = AddrBsr;
                        uart_wdata_o = {16'd0, r_div};
                    end else if (w_tx_sel) begin
                        uart_sel_o   = 1'b1;
                        uart_we_o    = 1'b1;
                        uart_addr_o  = AddrOdr;
                        uart_wdata_o = {24'd0, w_grant1 ? req1_data_i : req0_data_i};
                        req0_ready_o = !w_grant1;
                        req1_ready_o = w_grant1;
                    end
                end
                StIdWait: begin
                    rx_valid_o = 1'b1;
                    rx_data_o  = uart_rdata_i[7:0];
                    rx_fe_o    = r_sr[2];
                end
                StClr: begin
                    uart_sel_o  = 1'b1;
                    uart_we_o   = 1'b1;
                    uart_addr_o = AddrSr;
                end
                default: ;
            endcase
        end
    end

endmodule
